// File: rtl/lock_prober.sv
// Brute-force combination prober: walks X through all 16 codes, pulsing enter_n and
// clearing alarms, until the lock reports OPEN. Optional 7-segment readout via LOCK_PROBER_HEX_EN.
module lock_prober #(
    parameter int         PRESS_CYCLES  = 2,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] START_CODE    = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] lock_state,
    output logic [3:0] X,
    output logic       enter_n,
    output logic       lock_rst_n,
    output logic       busy,
    output logic       found,
    output logic [4:0] attempts
`ifdef LOCK_PROBER_HEX_EN
    ,
    output logic [6:0] hex
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_PRESS,
        S_SETTLE,
        S_CLEAR,
        S_FOUND,
        S_EXHAUST
    } state_t;

    localparam logic [2:0] LS_OPEN  = 3'b010;
    localparam logic [2:0] LS_ALARM = 3'b011;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_x, w_x_nxt;
    logic [3:0] w_x_inc;
    logic [4:0] r_att, w_att_nxt;
    logic       r_found, w_found_nxt;
    logic       r_enter_n, r_lock_rst_n, r_busy;

    assign w_x_inc = r_x + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_att_nxt   = r_att;
        w_found_nxt = r_found;
        case (r_state)
            S_IDLE, S_FOUND, S_EXHAUST: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                    w_x_nxt     = START_CODE;
                    w_att_nxt   = 5'd0;
                    w_found_nxt = 1'b0;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_PRESS;
                w_cnt_nxt   = 4'(PRESS_CYCLES - 1);
                w_att_nxt   = r_att + 5'd1;
            end
            S_PRESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = 4'(SETTLE_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_SETTLE: begin
                // lock_state is only trusted on the final settle clock
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (lock_state == LS_OPEN) begin
                    w_state_nxt = S_FOUND;
                    w_found_nxt = 1'b1;
                end else if (lock_state == LS_ALARM) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = 4'(PRESS_CYCLES - 1);
                end else begin
                    w_x_nxt     = w_x_inc;
                    w_state_nxt = (w_x_inc == START_CODE) ? S_EXHAUST : S_DRIVE;
                end
            end
            S_CLEAR: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_x_nxt     = w_x_inc;
                    w_state_nxt = (w_x_inc == START_CODE) ? S_EXHAUST : S_DRIVE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight off flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_x          <= START_CODE;
            r_att        <= 5'd0;
            r_found      <= 1'b0;
            r_enter_n    <= 1'b1;
            r_lock_rst_n <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_x          <= w_x_nxt;
            r_att        <= w_att_nxt;
            r_found      <= w_found_nxt;
            r_enter_n    <= (w_state_nxt != S_PRESS);
            r_lock_rst_n <= (w_state_nxt != S_CLEAR);
            r_busy       <= (w_state_nxt == S_DRIVE) || (w_state_nxt == S_PRESS) ||
                            (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CLEAR);
        end
    end

    assign X          = r_x;
    assign enter_n    = r_enter_n;
    assign lock_rst_n = r_lock_rst_n;
    assign busy       = r_busy;
    assign found      = r_found;
    assign attempts   = r_att;

`ifdef LOCK_PROBER_HEX_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    logic [6:0] r_hex, w_hex_nxt;

    always_comb begin
        w_hex_nxt = seg7(w_x_nxt);
        if (w_state_nxt == S_IDLE)
            w_hex_nxt = 7'b1111110;
        else if (w_state_nxt == S_EXHAUST)
            w_hex_nxt = 7'b0110000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hex <= 7'b1111110;
        else       r_hex <= w_hex_nxt;
    end

    assign hex = r_hex;
`endif

endmodule

// File: tb/tb_lock_prober.sv
// Directed bench for lock_prober: default instance plus a START_CODE=E instance,
// each driven by a small behavioural lock that answers from the presented code.
module tb_lock_prober;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [2:0] ls;
    logic [3:0] x;
    logic       en_n, lrst_n, busy, found;
    logic [4:0] att;

    logic       reset_e, start_e;
    logic [2:0] ls_e;
    logic [3:0] x_e;
    logic       en_n_e, lrst_n_e, busy_e, found_e;
    logic [4:0] att_e;
`ifdef LOCK_PROBER_HEX_EN
    logic [6:0] hex, hex_e;
`endif

    logic       open_en, alarm_en;
    logic [3:0] open_code, alarm_code;

    int total = 0, bad = 0;
    int cyc, rlow, rfirst, glitch;
    logic [3:0] prev_x;
    logic [3:0] xs[4];
    int idx;

    always #5 clk = ~clk;

    assign ls   = (open_en && x == open_code)   ? 3'b010 :
                  (alarm_en && x == alarm_code) ? 3'b011 : 3'b000;
    assign ls_e = (x_e == 4'h1) ? 3'b010 : 3'b000;

    lock_prober dut (
        .clk(clk), .reset(reset), .start(start), .lock_state(ls),
        .X(x), .enter_n(en_n), .lock_rst_n(lrst_n), .busy(busy),
        .found(found), .attempts(att)
`ifdef LOCK_PROBER_HEX_EN
        , .hex(hex)
`endif
    );

    lock_prober #(.START_CODE(4'hE)) dut_e (
        .clk(clk), .reset(reset_e), .start(start_e), .lock_state(ls_e),
        .X(x_e), .enter_n(en_n_e), .lock_rst_n(lrst_n_e), .busy(busy_e),
        .found(found_e), .attempts(att_e)
`ifdef LOCK_PROBER_HEX_EN
        , .hex(hex_e)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!lrst_n) begin
            rlow++;
            if (rfirst < 0) rfirst = cyc;
        end
        if (!en_n && x != prev_x) glitch++;
        prev_x = x;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; rlow = 0; rfirst = -1; glitch = 0; prev_x = x;
    endtask

    initial begin
        reset = 1'b1; reset_e = 1'b1; start = 1'b0; start_e = 1'b0;
        open_en = 1'b0; alarm_en = 1'b0; open_code = 4'h0; alarm_code = 4'h0;
        cyc = 0; rlow = 0; rfirst = -1; glitch = 0; prev_x = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x, 4'h0);
        chk("rst_enter_n", en_n, 1'b1);
        chk("rst_lock_rst_n", lrst_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_attempts", att, 5'd0);
`ifdef LOCK_PROBER_HEX_EN
        chk("rst_hex", hex, 7'b1111110);
`endif
        @(negedge clk);
        reset = 1'b0; reset_e = 1'b0;
        step();

        // lock opens on 6; a stray start during the first PRESS must be ignored
        open_en = 1'b1; open_code = 4'h6;
        kick();
        chk("a_drive_busy", busy, 1'b1);
        chk("a_drive_x", x, 4'h0);
        chk("a_drive_enter_n", en_n, 1'b1);
        chk("a_drive_att", att, 5'd0);
        step();
        chk("a_press_enter_n", en_n, 1'b0);
        chk("a_press_att", att, 5'd1);
`ifdef LOCK_PROBER_HEX_EN
        chk("a_hex_zero", hex, 7'b0000001);
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        chk("a_ignore_x", x, 4'h0);
        chk("a_ignore_att", att, 5'd1);
        while (!found && cyc < 200) step();
        chk("a_cycles", cyc, 49);
        chk("a_found", found, 1'b1);
        chk("a_x", x, 4'h6);
        chk("a_att", att, 5'd7);
        chk("a_busy", busy, 1'b0);
        chk("a_enter_n", en_n, 1'b1);
        chk("a_no_alarm", rlow, 0);

        // alarm on the second wrong code, then opens on 9
        open_code = 4'h9; alarm_en = 1'b1; alarm_code = 4'h1;
        kick();
        chk("b_found_cleared", found, 1'b0);
        while (!found && cyc < 300) step();
        chk("b_rst_low_cycles", rlow, 2);
        chk("b_rst_first", rfirst, 14);
        chk("b_cycles", cyc, 72);
        chk("b_found", found, 1'b1);
        chk("b_x", x, 4'h9);
        chk("b_att", att, 5'd10);
        chk("b_x_stable", glitch, 0);

        // never opens: exhaust all 16 codes
        open_en = 1'b0; alarm_en = 1'b0;
        kick();
        while (busy && cyc < 300) step();
        chk("c_cycles", cyc, 112);
        chk("c_busy", busy, 1'b0);
        chk("c_found", found, 1'b0);
        chk("c_att", att, 5'd16);
        chk("c_x", x, 4'h0);
        chk("c_x_stable", glitch, 0);
`ifdef LOCK_PROBER_HEX_EN
        chk("c_hex_e", hex, 7'b0110000);
`endif

        // reset during PRESS of the third attempt
        open_en = 1'b1; open_code = 4'h6;
        kick();
        while (cyc < 15) step();
        chk("d_press_enter_n", en_n, 1'b0);
        chk("d_press_att", att, 5'd3);
        chk("d_press_x", x, 4'h2);
        reset = 1'b1;
        #1;
        chk("d_rst_enter_n", en_n, 1'b1);
        chk("d_rst_lock_rst_n", lrst_n, 1'b1);
        chk("d_rst_busy", busy, 1'b0);
        chk("d_rst_att", att, 5'd0);
        chk("d_rst_x", x, 4'h0);
        chk("d_rst_found", found, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        chk("d_no_resume_busy", busy, 1'b0);
        chk("d_no_resume_att", att, 5'd0);
        kick();
        chk("d_restart_x", x, 4'h0);
        chk("d_restart_busy", busy, 1'b1);
        while (!found && cyc < 200) step();
        chk("d_found", found, 1'b1);
        chk("d_x", x, 4'h6);
        chk("d_att", att, 5'd7);

        // START_CODE=E wraps through F and 0 to open on 1
        start_e = 1'b1;
        step();
        start_e = 1'b0;
        cyc = 0; idx = 0;
        while (!found_e && cyc < 100) begin
            if (cyc % 7 == 0 && idx < 4) begin
                xs[idx] = x_e;
                idx++;
            end
            step();
        end
        chk("e_x0", xs[0], 4'hE);
        chk("e_x1", xs[1], 4'hF);
        chk("e_x2", xs[2], 4'h0);
        chk("e_x3", xs[3], 4'h1);
        chk("e_found", found_e, 1'b1);
        chk("e_x", x_e, 4'h1);
        chk("e_att", att_e, 5'd4);
        chk("e_cycles", cyc, 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_prober.md
LOCK_PROBER -- requirements
Module: lock_prober

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 2, meaning the enter_n low time and the lock_rst_n low time, in clocks (legal 1..15).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning clocks with enter_n high before lock_state is sampled (legal 2..15).
REQ-003 SHALL have parameter START_CODE, default 4'h0, meaning the first candidate code tried.
REQ-004 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-005 SHALL have port reset, input, 1; asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1; one-cycle request to begin a search.
REQ-007 SHALL have port lock_state, input, 3; lock status: 000 INERT, 001 CHECK_ALARM, 010 OPEN, 011 ALARM, 101 CHANGE.
REQ-008 SHALL have port X, output, 4; candidate code driven to the lock.
REQ-009 SHALL have port enter_n, output, 1; active-low enter button to the lock.
REQ-010 SHALL have port lock_rst_n, output, 1; active-low lock reset used to clear ALARM.
REQ-011 SHALL have port busy, output, 1; high while a search is in progress.
REQ-012 SHALL have port found, output, 1; high when the last search ended on OPEN.
REQ-013 SHALL have port attempts, output, 5; number of codes tried in the current or last search (0..16).

Function
REQ-014 SHALL implement the states IDLE, DRIVE, PRESS, SETTLE, CLEAR, FOUND and EXHAUST.
REQ-015 SHALL move from IDLE, FOUND or EXHAUST to DRIVE on start=1, loading X=START_CODE, clearing attempts and clearing found.
REQ-016 SHALL ignore start while busy=1.
REQ-017 DRIVE: hold X stable for 1 cycle with enter_n=1, then go to PRESS.
REQ-018 PRESS: drive enter_n=0 for exactly PRESS_CYCLES cycles, increment attempts once on entry, then go to SETTLE.
REQ-019 SETTLE: drive enter_n=1 for SETTLE_CYCLES cycles, then sample lock_state in the last SETTLE cycle.
REQ-020 On sampled 010 (OPEN): go to FOUND with found=1, busy=0, and X holding the winning code.
REQ-021 On sampled 011 (ALARM): go to CLEAR, drive lock_rst_n=0 for PRESS_CYCLES cycles, and continue with the next code.
REQ-022 On any other sampled value: continue with the next code.
REQ-023 Next code: X increments modulo 16; if the new X equals START_CODE (16 codes tried), go to EXHAUST with found=0 and busy=0, otherwise go to DRIVE.
REQ-024 X SHALL change only in IDLE/FOUND/EXHAUST exit or at the transition into DRIVE, and never while enter_n=0.
REQ-025 A missed attempt without alarm SHALL take 1+PRESS_CYCLES+SETTLE_CYCLES cycles, DRIVE to DRIVE.
REQ-026 busy SHALL be 1 in DRIVE, PRESS, SETTLE and CLEAR, and 0 otherwise.
REQ-027 enter_n and lock_rst_n SHALL be registered outputs and glitch-free.

Reset
REQ-028 With reset=1, asynchronously force: state IDLE, X=START_CODE, enter_n=1, lock_rst_n=1, busy=0, found=0, attempts=0.
REQ-029 Reset mid-search SHALL abort immediately and release enter_n/lock_rst_n high; no resumption occurs after reset deasserts.

Configuration
REQ-030 With macro LOCK_PROBER_HEX_EN defined, the module SHALL add output hex[6:0], active-low segments {a,b,c,d,e,f,g}, showing X as 0-F while busy or in FOUND, 'E' (7'b0110000) in EXHAUST and '-' (7'b1111110) in IDLE, registered.
REQ-031 Without LOCK_PROBER_HEX_EN, the hex port and its logic SHALL be absent; all other behaviour is identical.

Verification (defaults unless stated)
REQ-032 Reset, then start; the lock model opens on 4'h6 -> found=1 and X=6 after 7 attempts; attempts=7; 49 cycles from the first DRIVE to FOUND.
REQ-033 Lock model alarms on the second wrong code -> lock_rst_n low for 2 cycles after the second SETTLE; search continues to the code 4'h9; found=1.
REQ-034 Lock model never opens -> EXHAUST, attempts=16, found=0, X=START_CODE, busy=0.
REQ-035 START_CODE=4'hE, lock opens on 4'h1 -> X sequence E,F,0,1 (wrap); found=1; attempts=4.
REQ-036 reset pulsed during PRESS of attempt 3 -> enter_n=1 within the same cycle; all outputs at reset values; a second start restarts at START_CODE.
REQ-037 start pulsed while busy -> no change to X or attempts; with LOCK_PROBER_HEX_EN, hex=7'b0000001 ('0') during the first attempt.
